// File: rtl/score_keeper.sv
// Match flow and scoring downstream of the physics engine: counts rally winners,
// paces point pauses on frame_tick and drives BCD digits. Define SCORE_WIN_BY_TWO_EN for win-by-two.
module score_keeper #(
  parameter int WIN_SCORE    = 15,
  parameter int PAUSE_FRAMES = 90,
  parameter int SCORE_W      = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       game_over,
  input  logic [1:0] winner,
  input  logic       start,
  output logic       freeze,
  output logic       point_pulse,
  output logic       match_over,
  output logic [1:0] match_winner,
  output logic [3:0] p1_tens,
  output logic [3:0] p1_ones,
  output logic [3:0] p2_tens,
  output logic [3:0] p2_ones,
  output logic [1:0] state
);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, PAUSE = 2'd2, OVER = 2'd3} state_t;

  localparam logic [SCORE_W-1:0] SAT_V = SCORE_W'(99);
  localparam logic [SCORE_W-1:0] WIN_V = SCORE_W'(WIN_SCORE);

  // Scores stay within 0..99, so at most nine subtractions of ten are needed.
  function automatic logic [7:0] to_bcd(input logic [SCORE_W-1:0] v);
    logic [3:0]         t;
    logic [SCORE_W-1:0] r;
    t = 4'd0;
    r = v;
    for (int i = 0; i < 9; i++) begin
      if (r >= SCORE_W'(10)) begin
        r = r - SCORE_W'(10);
        t = t + 4'd1;
      end
    end
    return {t, r[3:0]};
  endfunction

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] p1_q, p1_d, p2_q, p2_d;
  logic [7:0]         p1_bcd_q, p1_bcd_d, p2_bcd_q, p2_bcd_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               go_dly_q, start_dly_q;
  logic               freeze_q, freeze_d;
  logic               point_pulse_q, point_pulse_d;
  logic               match_over_q, match_over_d;
  logic [1:0]         match_winner_q, match_winner_d;

  logic               point_evt, start_evt, won;
  logic [SCORE_W-1:0] p1_inc, p2_inc, scorer_new, other_score;

  always_comb begin
    state_d        = state_q;
    p1_d           = p1_q;
    p2_d           = p2_q;
    cnt_d          = cnt_q;
    match_winner_d = match_winner_q;
    point_pulse_d  = 1'b0;

    point_evt = game_over & ~go_dly_q & ((winner == 2'd1) | (winner == 2'd2)) & (state_q == PLAY);
    start_evt = start & ~start_dly_q;

    p1_inc      = (p1_q >= SAT_V) ? SAT_V : p1_q + SCORE_W'(1);
    p2_inc      = (p2_q >= SAT_V) ? SAT_V : p2_q + SCORE_W'(1);
    scorer_new  = (winner == 2'd1) ? p1_inc : p2_inc;
    other_score = (winner == 2'd1) ? p2_q : p1_q;
`ifdef SCORE_WIN_BY_TWO_EN
    won = ((scorer_new >= WIN_V) &&
           ({1'b0, scorer_new} >= ({1'b0, other_score} + (SCORE_W+1)'(2)))) ||
          (scorer_new == SAT_V);
`else
    won = (scorer_new >= WIN_V);
`endif

    case (state_q)
      IDLE: if (start_evt) state_d = PLAY;
      PLAY: begin
        if (point_evt) begin
          if (winner == 2'd1) p1_d = p1_inc;
          else                p2_d = p2_inc;
          point_pulse_d = 1'b1;
          if (won) begin
            state_d        = OVER;
            match_winner_d = winner;
          end else begin
            state_d = PAUSE;
            cnt_d   = 8'(PAUSE_FRAMES);
          end
        end
      end
      PAUSE: begin
        // Rally edges are deliberately ignored here; only frame_tick advances.
        if (frame_tick) begin
          cnt_d = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
          if (cnt_q <= 8'd1) state_d = PLAY;
        end
      end
      OVER: begin
        if (start_evt) begin
          p1_d           = '0;
          p2_d           = '0;
          match_winner_d = 2'd0;
          state_d        = PLAY;
        end
      end
      default: state_d = IDLE;
    endcase

    p1_bcd_d     = to_bcd(p1_d);
    p2_bcd_d     = to_bcd(p2_d);
    freeze_d     = (state_d != PLAY);
    match_over_d = (state_d == OVER);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      p1_q           <= '0;
      p2_q           <= '0;
      p1_bcd_q       <= 8'd0;
      p2_bcd_q       <= 8'd0;
      cnt_q          <= 8'd0;
      go_dly_q       <= 1'b0;
      start_dly_q    <= 1'b0;
      freeze_q       <= 1'b1;
      point_pulse_q  <= 1'b0;
      match_over_q   <= 1'b0;
      match_winner_q <= 2'd0;
    end else begin
      state_q        <= state_d;
      p1_q           <= p1_d;
      p2_q           <= p2_d;
      p1_bcd_q       <= p1_bcd_d;
      p2_bcd_q       <= p2_bcd_d;
      cnt_q          <= cnt_d;
      go_dly_q       <= game_over;
      start_dly_q    <= start;
      freeze_q       <= freeze_d;
      point_pulse_q  <= point_pulse_d;
      match_over_q   <= match_over_d;
      match_winner_q <= match_winner_d;
    end
  end

  assign freeze       = freeze_q;
  assign point_pulse  = point_pulse_q;
  assign match_over   = match_over_q;
  assign match_winner = match_winner_q;
  assign p1_tens      = p1_bcd_q[7:4];
  assign p1_ones      = p1_bcd_q[3:0];
  assign p2_tens      = p2_bcd_q[7:4];
  assign p2_ones      = p2_bcd_q[3:0];
  assign state        = state_q;

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Sits directly downstream of the physics engine.
- Watches the engine's end-of-rally flag and winner code, and keeps per-player scores.
- Runs the match flow: idle, play, point pause, match over.
- Drives a freeze output that the top level uses to mask player controls into the physics engine. It also drives BCD score digits for the scoreboard renderer.

Parameters:
- WIN_SCORE, 15, points needed to win the match (1..99).
- PAUSE_FRAMES, 90, number of frame_tick pulses the game stays frozen after each point (1..255).
- SCORE_W, 7, width of the binary score registers. Must hold 99.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- frame_tick  input  1  one-clk 60 Hz pulse, the same strobe that drives the physics engine
- game_over  input  1  level from the physics engine, high for one frame period when the ball lands
- winner  input  2  from the physics engine: 1 = P1 scored, 2 = P2 scored; 0 and 3 are invalid
- start  input  1  start/restart button, level, already synchronised
- freeze  output  1  high = top level forces all player move/jump/smash inputs to 0
- point_pulse  output  1  one-clk pulse after each accepted point
- match_over  output  1  high while in OVER
- match_winner  output  2  0 = none, 1 = P1, 2 = P2
- p1_tens, p1_ones  output  4 each  BCD digits of the P1 score
- p2_tens, p2_ones  output  4 each  BCD digits of the P2 score
- state  output  2  IDLE=0, PLAY=1, PAUSE=2, OVER=3

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-pause or mid-match):
  - state=IDLE, both scores 0, all BCD digits 0.
  - freeze=1, point_pulse=0, match_over=0, match_winner=0.
  - pause counter 0; go_d and start_d both 0.
- Edge detection: go_d and start_d are registered copies of game_over and start.
  - point_evt = game_over & ~go_d & (winner==1 | winner==2) & state==PLAY.
  - start_evt = start & ~start_d.
- IDLE: freeze=1. start_evt moves to PLAY.
- PLAY: freeze=0. A point_evt does all of the following on the same clk edge:
  - increment the scorer's register;
  - update that scorer's BCD digits, computed from the next value;
  - set point_pulse for the following clk;
  - go to OVER if the new score reaches WIN_SCORE, otherwise go to PAUSE with the pause counter loaded with PAUSE_FRAMES.
- PAUSE: freeze=1.
  - Each frame_tick decrements the counter.
  - The frame_tick that decrements it from 1 to 0 moves to PLAY.
  - game_over edges in this state are ignored.
- OVER: freeze=1, match_over=1, match_winner=last scorer.
  - start_evt clears both scores, all digits, match_over and match_winner, then goes to PLAY. No IDLE step.
- winner 0 or 3 on a game_over rising edge: no score change, no state change, no pulse.
- Scores never exceed WIN_SCORE in default mode. Arithmetic is unsigned with saturation at 99.
- start_evt in PLAY or PAUSE has no effect.
- Coincidences on the same clk:
  - point_evt together with frame_tick: point handling only.
  - game_over rising on the PAUSE to PLAY exit clk: not counted, because state was not PLAY at that edge.
- point_pulse is exactly 1 clk wide. The BCD digits are registered and valid on the same clk as point_pulse.

Optional Feature:
- Macro: SCORE_WIN_BY_TWO_EN.
- Defined:
  - The match ends only when the scorer has at least WIN_SCORE points and leads by 2 or more. Otherwise it goes to PAUSE.
  - Scores may exceed WIN_SCORE.
  - If a score reaches the saturation value 99, that scorer wins regardless of lead.
- Undefined: first to WIN_SCORE wins, as described in Behaviour.

Test Plan:
- Reset, then start held 1 for 3 clks: state 0 then 1 after one clk. Only one start_evt is taken. freeze goes 1 to 0.
- In PLAY, game_over high for 5 clks with winner=1: p1_ones=1, exactly one point_pulse, state=PAUSE, freeze=1. After 90 frame_ticks, state=PLAY.
- In PLAY, game_over rising with winner=0 and then winner=3: scores stay 0, no point_pulse, state stays PLAY.
- WIN_SCORE=15, P2 wins 15 points: p2_tens=1, p2_ones=5, state=OVER, match_winner=2. A further game_over edge changes nothing. start_evt clears everything and goes to PLAY.
- With SCORE_WIN_BY_TWO_EN defined and the score at 14-14, P1 scores: state=PAUSE. P1 scores again: state=OVER at 16-14, match_winner=1.
- Assert rst during PAUSE with the counter at 40: all outputs return immediately to their reset values, state=IDLE.
